// File: rtl/ahb3lite_bus_arbiter.sv
// rtl/ahb3lite_bus_arbiter.sv - AHB3-Lite round-robin arbiter with fixed-burst locking (option macro: ARB_FIXED_PRIORITY_EN)
module ahb3lite_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int PARK_MASTER = 0
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS*32-1:0] m_haddr,
    input  logic [NUM_MASTERS*2-1:0]  m_htrans,
    input  logic [NUM_MASTERS*3-1:0]  m_hburst,
    input  logic [NUM_MASTERS*3-1:0]  m_hsize,
    input  logic [NUM_MASTERS-1:0]    m_hwrite,
    input  logic                      HREADY,
    input  logic                      HRESP,
    output logic [NUM_MASTERS-1:0]    HGRANT,
    output logic [1:0]                HMASTER,
    output logic [1:0]                HMASTER_D,
    output logic [31:0]               HADDR,
    output logic [1:0]                HTRANS,
    output logic [2:0]                HBURST,
    output logic [2:0]                HSIZE,
    output logic                      HWRITE
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [1:0] PARK_IDX  = PARK_MASTER[1:0];

    typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_BURST, ST_ARB} state_t;

    state_t                   r_state;
    logic [1:0]               r_own;
    logic [4:0]               r_beat_cnt;
    logic                     r_lock;
    logic [NUM_MASTERS-1:0]   r_hgrant;
    logic [1:0]               r_hmaster;
    logic [1:0]               r_hmaster_d;

    logic                     w_own_ok;
    int                       w_idx;
    logic                     w_owner_req;
    logic [1:0]               w_htrans;
    logic [2:0]               w_hburst;
    logic                     w_fixed;
    logic [4:0]               w_len;
    logic                     w_accept;
    logic                     w_others;
    logic                     w_elig;
    logic                     w_any;
    logic [1:0]               w_next;
    int                       w_best;
    int                       w_dist;
    logic [NUM_MASTERS-1:0]   w_own_oh;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [1:0] idx);
        logic [NUM_MASTERS-1:0] oh;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            oh[i] = (idx == 2'(i));
        end
        return oh;
    endfunction

    // Owner decode and slave-side control mux; a non-requesting owner presents IDLE
    always_comb begin
        w_own_ok    = (int'(r_own) < NUM_MASTERS);
        w_idx       = w_own_ok ? int'(r_own) : PARK_MASTER;
        w_owner_req = w_own_ok && m_req[w_idx];
        w_htrans    = w_owner_req ? m_htrans[2*w_idx +: 2] : TR_IDLE;
        w_hburst    = m_hburst[3*w_idx +: 3];
        w_fixed     = (w_hburst >= 3'd2);
        case (w_hburst)
            3'd2, 3'd3: w_len = 5'd4;
            3'd4, 3'd5: w_len = 5'd8;
            3'd6, 3'd7: w_len = 5'd16;
            default:    w_len = 5'd1;
        endcase
        w_accept  = HREADY && ((w_htrans == TR_NONSEQ) || (w_htrans == TR_SEQ));
        w_own_oh  = onehot(w_own_ok ? r_own : PARK_IDX);
        w_others  = |(m_req & ~w_own_oh);
        w_any     = |m_req;
        // SINGLE beats and IDLE cycles release the bus to a waiting master; INCR holds it
        w_elig    = !w_owner_req ||
                    (w_others && ((w_htrans == TR_IDLE) ||
                                  ((w_htrans == TR_NONSEQ) && (w_hburst == BU_SINGLE))));
        HADDR     = m_haddr[32*w_idx +: 32];
        HTRANS    = w_htrans;
        HBURST    = w_hburst;
        HSIZE     = m_hsize[3*w_idx +: 3];
        HWRITE    = m_hwrite[w_idx];
    end

    // Next owner: smallest priority distance wins; the current owner ranks last in round-robin
    always_comb begin
        w_next = PARK_IDX;
        w_best = NUM_MASTERS + 1;
        w_dist = 0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (m_req[j]) begin
`ifdef ARB_FIXED_PRIORITY_EN
                w_dist = j;
`else
                w_dist = (j - int'(r_own) + 2*NUM_MASTERS) % NUM_MASTERS;
                if (w_dist == 0) begin
                    w_dist = NUM_MASTERS;
                end
`endif
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_next = 2'(j);
                end
            end
        end
    end

    // Arbitration FSM, beat counter, burst lock and registered grant outputs
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_PARK;
            r_own       <= PARK_IDX;
            r_beat_cnt  <= 5'd0;
            r_lock      <= 1'b0;
            r_hgrant    <= onehot(PARK_IDX);
            r_hmaster   <= PARK_IDX;
            r_hmaster_d <= PARK_IDX;
        end else begin
            if (HREADY) begin
                r_hgrant    <= w_own_oh;
                r_hmaster   <= w_own_ok ? r_own : PARK_IDX;
                r_hmaster_d <= r_hmaster;
            end
            if (!w_own_ok) begin
                r_state    <= ST_PARK;
                r_own      <= PARK_IDX;
                r_lock     <= 1'b0;
                r_beat_cnt <= 5'd0;
            end else begin
                case (r_state)
                    ST_PARK: begin
                        if (HREADY && w_any) begin
                            r_own   <= m_req[PARK_MASTER] ? PARK_IDX : w_next;
                            r_state <= ST_OWN;
                        end
                    end
                    ST_OWN: begin
                        if (w_accept) begin
                            r_beat_cnt <= (w_htrans == TR_NONSEQ) ? 5'd1 : r_beat_cnt + 5'd1;
                        end
                        if (w_accept && (w_htrans == TR_NONSEQ) && w_fixed) begin
                            r_lock  <= 1'b1;
                            r_state <= ST_BURST;
                        end else if (HREADY && w_elig) begin
                            r_state <= ST_ARB;
                        end
                    end
                    ST_BURST: begin
                        if (!HREADY && HRESP) begin
                            r_lock  <= 1'b0;
                            r_state <= ST_OWN;
                        end else if (w_accept) begin
                            if (w_htrans == TR_NONSEQ) begin
                                r_beat_cnt <= 5'd1;
                                r_lock     <= w_fixed;
                                r_state    <= w_fixed ? ST_BURST : ST_OWN;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 5'd1;
                                if (r_beat_cnt == w_len - 5'd1) begin
                                    r_lock  <= 1'b0;
                                    r_state <= ST_OWN;
                                end
                            end
                        end
                    end
                    ST_ARB: begin
                        r_own   <= w_any ? w_next : PARK_IDX;
                        r_state <= w_any ? ST_OWN : ST_PARK;
                    end
                    default: begin
                        r_state <= ST_PARK;
                    end
                endcase
            end
        end
    end

    assign HGRANT    = r_hgrant;
    assign HMASTER   = r_hmaster;
    assign HMASTER_D = r_hmaster_d;

endmodule

// File: tb/tb_ahb3lite_bus_arbiter.sv
// tb/tb_ahb3lite_bus_arbiter.sv - directed self-checking bench for ahb3lite_bus_arbiter
module tb_ahb3lite_bus_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  m_req;
    logic [63:0] m_haddr;
    logic [3:0]  m_htrans;
    logic [5:0]  m_hburst;
    logic [5:0]  m_hsize;
    logic [1:0]  m_hwrite;
    logic        HREADY;
    logic        HRESP;
    logic [1:0]  HGRANT;
    logic [1:0]  HMASTER;
    logic [1:0]  HMASTER_D;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;

    int n_checks = 0;
    int n_fail   = 0;

    ahb3lite_bus_arbiter #(.NUM_MASTERS(2), .PARK_MASTER(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .m_req(m_req), .m_haddr(m_haddr),
        .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hsize(m_hsize), .m_hwrite(m_hwrite),
        .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT), .HMASTER(HMASTER),
        .HMASTER_D(HMASTER_D), .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST),
        .HSIZE(HSIZE), .HWRITE(HWRITE)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv(input int i, input logic req, input logic [1:0] tr,
                       input logic [2:0] hb, input logic [31:0] a);
        m_req[i]              = req;
        m_htrans[2*i +: 2]    = tr;
        m_hburst[3*i +: 3]    = hb;
        m_haddr[32*i +: 32]   = a;
    endtask

    task automatic do_reset();
        HRESET   = 1'b1;
        m_req    = '0;
        m_haddr  = '0;
        m_htrans = '0;
        m_hburst = '0;
        m_hsize  = '0;
        m_hwrite = '0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        tick();
        tick();
        HRESET   = 1'b0;
    endtask

    initial begin
        HRESET   = 1'b1;
        m_req    = '0;
        m_haddr  = '0;
        m_htrans = '0;
        m_hburst = '0;
        m_hsize  = '0;
        m_hwrite = '0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        #2;
        chk("rst_hgrant", 32'(HGRANT), 32'h1);
        chk("rst_hmaster", 32'(HMASTER), 32'h0);
        chk("rst_hmaster_d", 32'(HMASTER_D), 32'h0);
        chk("rst_htrans", 32'(HTRANS), 32'h0);

        // Test 1: reset asserted in the middle of an m1 INCR4
        do_reset();
        drv(1, 1'b1, 2'd0, 3'd3, 32'h40);
        tick();
        drv(1, 1'b1, 2'd2, 3'd3, 32'h40);
        tick();
        drv(1, 1'b1, 2'd3, 3'd3, 32'h44);
        tick();
        chk("t1_pre_hgrant", 32'(HGRANT), 32'h2);
        chk("t1_pre_hmaster", 32'(HMASTER), 32'h1);
        chk("t1_pre_htrans", 32'(HTRANS), 32'h3);
        HRESET = 1'b1;
        #1;
        chk("t1_rst_hgrant", 32'(HGRANT), 32'h1);
        chk("t1_rst_hmaster", 32'(HMASTER), 32'h0);
        chk("t1_rst_htrans", 32'(HTRANS), 32'h0);

        // Owner not requesting: slave-side HTRANS forced to IDLE
        do_reset();
        drv(0, 1'b0, 2'd2, 3'd0, 32'h10);
        #1;
        chk("idle_force", 32'(HTRANS), 32'h0);

        // Test 2 / 6: both masters issuing SINGLE NONSEQ continuously
        do_reset();
        drv(0, 1'b1, 2'd2, 3'd0, 32'h1000);
        drv(1, 1'b1, 2'd2, 3'd0, 32'h2000);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t6_hgrant", 32'(HGRANT), 32'h1);
            chk("t6_hmaster", 32'(HMASTER), 32'h0);
        end
`else
        tick();
        tick();
        tick();
        chk("t2_e3_haddr", HADDR, 32'h2000);
        chk("t2_e3_hgrant", 32'(HGRANT), 32'h1);
        tick();
        chk("t2_e4_hgrant", 32'(HGRANT), 32'h2);
        chk("t2_e4_hmaster", 32'(HMASTER), 32'h1);
        chk("t2_e4_hmaster_d", 32'(HMASTER_D), 32'h0);
        tick();
        chk("t2_e5_hmaster_d", 32'(HMASTER_D), 32'h1);
        tick();
        chk("t2_e6_hgrant", 32'(HGRANT), 32'h1);
        chk("t2_e6_hmaster", 32'(HMASTER), 32'h0);
        chk("t2_e6_hmaster_d", 32'(HMASTER_D), 32'h1);
        tick();
        tick();
        chk("t2_e8_hgrant", 32'(HGRANT), 32'h2);
`endif

        // Test 3: m0 INCR8 at 0x100, m1 requests during beat 2
        do_reset();
        drv(0, 1'b1, 2'd0, 3'd5, 32'h100);
        tick();
        drv(0, 1'b1, 2'd2, 3'd5, 32'h100);
        m_hsize[2:0] = 3'd2;
        m_hwrite[0]  = 1'b1;
        #1;
        chk("t3_haddr", HADDR, 32'h100);
        chk("t3_hburst", 32'(HBURST), 32'h5);
        chk("t3_hsize", 32'(HSIZE), 32'h2);
        chk("t3_hwrite", 32'(HWRITE), 32'h1);
        tick();
        drv(1, 1'b1, 2'd0, 3'd0, 32'h0);
        for (int b = 2; b <= 8; b++) begin
            drv(0, 1'b1, 2'd3, 3'd5, 32'h100 + 32'(4*(b-1)));
            tick();
            chk("t3_lock_hgrant", 32'(HGRANT), 32'h1);
        end
        drv(0, 1'b1, 2'd0, 3'd5, 32'h120);
        tick();
        chk("t3_arb_hgrant", 32'(HGRANT), 32'h1);
        tick();
        chk("t3_post_arb_hgrant", 32'(HGRANT), 32'h1);
        tick();
        chk("t3_m1_hgrant", 32'(HGRANT), 32'h2);
        chk("t3_m1_hmaster", 32'(HMASTER), 32'h1);

        // Test 4: three wait states during m0 INCR4, m1 waiting
        do_reset();
        drv(0, 1'b1, 2'd0, 3'd3, 32'h300);
        drv(1, 1'b1, 2'd0, 3'd0, 32'h0);
        tick();
        drv(0, 1'b1, 2'd2, 3'd3, 32'h300);
        tick();
        drv(0, 1'b1, 2'd3, 3'd3, 32'h304);
        tick();
        drv(0, 1'b1, 2'd3, 3'd3, 32'h308);
        tick();
        drv(0, 1'b1, 2'd3, 3'd3, 32'h30c);
        HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t4_wait_hgrant", 32'(HGRANT), 32'h1);
            chk("t4_wait_hmaster_d", 32'(HMASTER_D), 32'h0);
        end
        HREADY = 1'b1;
        tick();
        drv(0, 1'b0, 2'd0, 3'd0, 32'h0);
        tick();
        tick();
        chk("t4_arb_hgrant", 32'(HGRANT), 32'h1);
        tick();
        chk("t4_hand_hgrant", 32'(HGRANT), 32'h2);
        chk("t4_hand_hmaster", 32'(HMASTER), 32'h1);
        tick();
        chk("t4_hand_hmaster_d", 32'(HMASTER_D), 32'h1);

        // Test 5: ERROR response on m1 WRAP4 beat 2, m0 waiting
        do_reset();
        drv(1, 1'b1, 2'd0, 3'd2, 32'h500);
        tick();
        drv(1, 1'b1, 2'd2, 3'd2, 32'h500);
        tick();
        chk("t5_m1_hgrant", 32'(HGRANT), 32'h2);
        drv(1, 1'b1, 2'd3, 3'd2, 32'h504);
        drv(0, 1'b1, 2'd2, 3'd0, 32'h200);
        tick();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        chk("t5_err_hgrant", 32'(HGRANT), 32'h2);
        HREADY = 1'b1;
        drv(1, 1'b1, 2'd0, 3'd2, 32'h508);
        tick();
        HRESP = 1'b0;
        tick();
        chk("t5_arb_hgrant", 32'(HGRANT), 32'h2);
        chk("t5_arb_htrans", 32'(HTRANS), 32'h2);
        chk("t5_arb_haddr", HADDR, 32'h200);
        tick();
        chk("t5_m0_hgrant", 32'(HGRANT), 32'h1);
        chk("t5_m0_hmaster", 32'(HMASTER), 32'h0);
        chk("t5_m0_hmaster_d", 32'(HMASTER_D), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
